dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-requester arbiter and sequencer for the data memory. Accepts load/store requests from the core load/store unit (port 0) and a debug/DMA master (port 1), serialises them onto the single data-memory port, checks alignment, and returns load data or completion on a per-port valid/ready response channel. Sits between the requesters and the data memory; the data memory sees exactly one access at a time.

## Interface
- ADDR_W, 32, request/memory address width
- DATA_W, 32, data width
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- req0_valid / req1_valid  input  1  request present
- req0_ready / req1_ready  output  1  request accepted this cycle when valid&ready
- req0_addr / req1_addr  input  ADDR_W  byte address
- req0_wdata / req1_wdata  input  DATA_W  store data (LSB-aligned)
- req0_we / req1_we  input  1  1 = store, 0 = load
- req0_size / req1_size  input  2  00 byte, 01 half, 10 word, 11 illegal
- req0_unsigned / req1_unsigned  input  1  zero-extend load (LBU/LHU)
- rsp0_valid / rsp1_valid  output  1  response present
- rsp0_ready / rsp1_ready  input  1  response consumed when valid&ready
- rsp0_rdata / rsp1_rdata  output  DATA_W  load result; 0 for stores and errors
- rsp0_err / rsp1_err  output  1  misaligned or illegal-size request
- mem_en  output  1  memory access active this cycle
- mem_we  output  1  store strobe (qualified by mem_en)
- mem_addr  output  ADDR_W  registered request address
- mem_wdata  output  DATA_W  registered store data
- mem_size  output  2  registered size
- mem_unsigned  output  1  registered unsigned flag
- mem_rdata  input  DATA_W  combinational, already-extended load data
- mem_ld_avail  input  1  memory can complete a load this cycle
- mem_sd_avail  input  1  memory can complete a store this cycle

## Operation
- States: IDLE, ISSUE, RESP. Reset: state=IDLE, last_grant=1, all outputs 0 except req*_ready per IDLE rule below.
- IDLE: req_ready asserted only to the selected port (winner among valid requests); at most one handshake per cycle. On handshake, latch addr/wdata/we/size/unsigned and granted port id.
- Alignment check on accept: size 11, half with addr[0]=1, or word with addr[1:0]!=0 -> error; go directly to RESP with err=1, rdata=0; no memory access.
- Legal request -> ISSUE. ISSUE: mem_en=1, mem_we=latched we, mem_* from latches. Stay in ISSUE while the relevant avail (ld for loads, sd for stores) is 0. When avail=1: capture mem_rdata (load) or 0 (store) at that edge, go to RESP.
- RESP: rsp_valid to granted port only, with captured rdata/err held stable until rsp_ready; on handshake -> IDLE, update last_grant to granted port.
- mem_en=0, mem_we=0 outside ISSUE. Ungranted port sees ready=0, rsp_valid=0.

## Timing
- Accept at edge T (IDLE). ISSUE cycle T..T+1; with avail high, rsp_valid high from T+2. Error path: rsp_valid from T+1.
- Store is written by memory at the edge ending the ISSUE cycle where sd_avail=1.
- Next accept earliest the cycle after the response handshake: peak one access per 3 cycles.
- Simultaneous valid on both ports: arbitration per Configuration; loser's valid must be held (not sampled again until IDLE).
- reset in any state: next cycle IDLE, pending response discarded, no rsp_valid; a store in ISSUE during reset is not guaranteed written (memory also in reset).

## Configuration
- DMEM_ARB_RR_EN defined: round-robin; on contention grant the port not equal to last_grant (port 0 wins first after reset). Single requester always granted.
- Undefined: fixed priority, port 0 always wins contention; last_grant unused.

## Test plan
- Port0 SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> mem_we pulse with mem_addr 0x10; load rsp0_rdata=0xDEADBEEF, err=0, rsp_valid 2 cycles after accept.
- Port1 LH addr 0x13 -> rsp1_err=1, rsp1_rdata=0, mem_en never asserted, rsp_valid 1 cycle after accept.
- Both valid every cycle, 4 loads each, RR_EN defined -> grants alternate 0,1,0,1...; undefined -> all 4 port0 grants before any port1.
- mem_ld_avail low 3 cycles during port0 LW -> ISSUE held 4 cycles, mem_addr stable, rsp0_valid on 5th cycle after accept.
- rsp0_ready held low 5 cycles -> rsp0_valid/rdata stable, req*_ready=0 throughout; port1 accepted cycle after handshake.
- reset asserted in ISSUE and in RESP -> next cycle IDLE, rsp_valid=0, mem_en=0, port0 granted first on next contention.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Bundle of the two requester channels, their response channels and the data-memory port.
// The arbiter connects through the slave modport; requesters and memory use the master modport.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req0_valid, req1_valid;
    logic              req0_ready, req1_ready;
    logic [ADDR_W-1:0] req0_addr, req1_addr;
    logic [DATA_W-1:0] req0_wdata, req1_wdata;
    logic              req0_we, req1_we;
    logic [1:0]        req0_size, req1_size;
    logic              req0_unsigned, req1_unsigned;

    logic              rsp0_valid, rsp1_valid;
    logic              rsp0_ready, rsp1_ready;
    logic [DATA_W-1:0] rsp0_rdata, rsp1_rdata;
    logic              rsp0_err, rsp1_err;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [1:0]        mem_size;
    logic              mem_unsigned;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ld_avail;
    logic              mem_sd_avail;

    modport slave (
        input  req0_valid, req1_valid, req0_addr, req1_addr, req0_wdata, req1_wdata,
               req0_we, req1_we, req0_size, req1_size, req0_unsigned, req1_unsigned,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp1_valid, rsp0_rdata, rsp1_rdata, rsp0_err, rsp1_err,
        input  rsp0_ready, rsp1_ready,
        output mem_en, mem_we, mem_addr, mem_wdata, mem_size, mem_unsigned,
        input  mem_rdata, mem_ld_avail, mem_sd_avail
    );

    modport master (
        output req0_valid, req1_valid, req0_addr, req1_addr, req0_wdata, req1_wdata,
               req0_we, req1_we, req0_size, req1_size, req0_unsigned, req1_unsigned,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp1_valid, rsp0_rdata, rsp1_rdata, rsp0_err, rsp1_err,
        output rsp0_ready, rsp1_ready,
        input  mem_en, mem_we, mem_addr, mem_wdata, mem_size, mem_unsigned,
        output mem_rdata, mem_ld_avail, mem_sd_avail
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter/sequencer: IDLE -> ISSUE -> RESP, one access in flight.
// Define DMEM_ARB_RR_EN for round-robin contention; otherwise port 0 has fixed priority.
module dmem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic           clk,
    input  logic           reset,
    dmem_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_e;

    state_e            state_q, state_d;
    logic              grant_q, grant_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
`ifdef DMEM_ARB_RR_EN
    logic              last_grant_q, last_grant_d;
`endif

    logic              sel;
    logic              sel_valid;
    logic              accept;
    logic              avail;
    logic              rsp_ready;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_we;
    logic [1:0]        sel_size;
    logic              sel_uns;

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lsb);
        case (size)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = lsb[0];
            2'b10:   misaligned = (lsb != 2'b00);
            default: misaligned = 1'b1;
        endcase
    endfunction

    // Winner among the valid requests; a lone requester always wins.
    always_comb begin
`ifdef DMEM_ARB_RR_EN
        sel = (bus.req0_valid && bus.req1_valid) ? ~last_grant_q : bus.req1_valid;
`else
        sel = ~bus.req0_valid & bus.req1_valid;
`endif
    end

    assign sel_valid = sel ? bus.req1_valid    : bus.req0_valid;
    assign sel_addr  = sel ? bus.req1_addr     : bus.req0_addr;
    assign sel_wdata = sel ? bus.req1_wdata    : bus.req0_wdata;
    assign sel_we    = sel ? bus.req1_we       : bus.req0_we;
    assign sel_size  = sel ? bus.req1_size     : bus.req0_size;
    assign sel_uns   = sel ? bus.req1_unsigned : bus.req0_unsigned;

    assign accept    = (state_q == IDLE) && sel_valid;
    assign avail     = we_q ? bus.mem_sd_avail : bus.mem_ld_avail;
    assign rsp_ready = grant_q ? bus.rsp1_ready : bus.rsp0_ready;

    always_comb begin
        // NOTE: every next-state signal gets its hold value first so no path infers a latch.
        state_d = state_q;
        grant_d = grant_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        size_d  = size_q;
        uns_d   = uns_q;
        rdata_d = rdata_q;
        err_d   = err_q;
`ifdef DMEM_ARB_RR_EN
        last_grant_d = last_grant_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    grant_d = sel;
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    we_d    = sel_we;
                    size_d  = sel_size;
                    uns_d   = sel_uns;
                    rdata_d = '0;
                    if (misaligned(sel_size, sel_addr[1:0])) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else begin
                        err_d   = 1'b0;
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (avail) begin
                    rdata_d = we_q ? '0 : bus.mem_rdata;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
`ifdef DMEM_ARB_RR_EN
                    last_grant_d = grant_q;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
`ifdef DMEM_ARB_RR_EN
            last_grant_q <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
`ifdef DMEM_ARB_RR_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    assign bus.req0_ready = accept & ~sel;
    assign bus.req1_ready = accept & sel;

    assign bus.rsp0_valid = (state_q == RESP) & ~grant_q;
    assign bus.rsp1_valid = (state_q == RESP) &  grant_q;
    assign bus.rsp0_rdata = bus.rsp0_valid ? rdata_q : '0;
    assign bus.rsp1_rdata = bus.rsp1_valid ? rdata_q : '0;
    assign bus.rsp0_err   = bus.rsp0_valid & err_q;
    assign bus.rsp1_err   = bus.rsp1_valid & err_q;

    assign bus.mem_en       = (state_q == ISSUE);
    assign bus.mem_we       = (state_q == ISSUE) & we_q;
    assign bus.mem_addr     = addr_q;
    assign bus.mem_wdata    = wdata_q;
    assign bus.mem_size     = size_q;
    assign bus.mem_unsigned = uns_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: vector table plus scoreboard queue, with a
// byte-addressed memory model behind the memory port. Honours DMEM_ARB_RR_EN.
module tb_dmem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam logic [1:0] SZ_B = 2'b00, SZ_H = 2'b01, SZ_W = 2'b10, SZ_X = 2'b11;

    typedef struct {
        bit          port;
        bit          we;
        logic [1:0]  size;
        bit          uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          stall;
        logic [31:0] exp_rdata;
        bit          exp_err;
    } vec_t;

    typedef struct {
        bit          port;
        logic [31:0] rdata;
        bit          err;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (.clk(clk), .reset(reset), .bus(bus));

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Memory model: little-endian bytes, combinational extended read, store at clock edge.
    logic [7:0] tb_mem [256] = '{default: 8'h00};
    logic [7:0] ma;
    logic [7:0] b0, b1, b2, b3;
    assign ma = bus.mem_addr[7:0];

    always_comb begin
        b0 = tb_mem[ma];
        b1 = tb_mem[ma + 8'd1];
        b2 = tb_mem[ma + 8'd2];
        b3 = tb_mem[ma + 8'd3];
        case (bus.mem_size)
            SZ_B:    bus.mem_rdata = bus.mem_unsigned ? {24'h0, b0} : {{24{b0[7]}}, b0};
            SZ_H:    bus.mem_rdata = bus.mem_unsigned ? {16'h0, b1, b0} : {{16{b1[7]}}, b1, b0};
            default: bus.mem_rdata = {b3, b2, b1, b0};
        endcase
    end

    always @(posedge clk) begin
        if (!reset && bus.mem_en && bus.mem_we && bus.mem_sd_avail) begin
            tb_mem[ma] <= bus.mem_wdata[7:0];
            if (bus.mem_size != SZ_B) tb_mem[ma + 8'd1] <= bus.mem_wdata[15:8];
            if (bus.mem_size == SZ_W) begin
                tb_mem[ma + 8'd2] <= bus.mem_wdata[23:16];
                tb_mem[ma + 8'd3] <= bus.mem_wdata[31:24];
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    function automatic vec_t mk(bit p, bit we, logic [1:0] sz, bit u, logic [31:0] a,
                                logic [31:0] wd, int st, logic [31:0] er, bit ee);
        vec_t v;
        v.port = p; v.we = we; v.size = sz; v.uns = u; v.addr = a; v.wdata = wd;
        v.stall = st; v.exp_rdata = er; v.exp_err = ee;
        return v;
    endfunction

    task automatic drive_req(input bit p, input bit v, input vec_t r);
        if (!p) begin
            bus.req0_valid = v; bus.req0_addr = r.addr; bus.req0_wdata = r.wdata;
            bus.req0_we = r.we; bus.req0_size = r.size; bus.req0_unsigned = r.uns;
        end else begin
            bus.req1_valid = v; bus.req1_addr = r.addr; bus.req1_wdata = r.wdata;
            bus.req1_we = r.we; bus.req1_size = r.size; bus.req1_unsigned = r.uns;
        end
    endtask

    // Called at a negedge with the request valid; returns once ready is seen (before the edge).
    task automatic wait_ready(input bit p, input string tag, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            #1;
            if ((p ? bus.req1_ready : bus.req0_ready) === 1'b1) begin
                ok = 1'b1;
                return;
            end
            @(negedge clk);
        end
        check({tag, " accept timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_rsp(input bit p, input string tag, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if ((p ? bus.rsp1_valid : bus.rsp0_valid) === 1'b1) begin
                ok = 1'b1;
                return;
            end
            @(negedge clk);
        end
        check({tag, " response timeout"}, 32'd0, 32'd1);
    endtask

    task automatic pop_check(input bit p, input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, " unexpected response"}, 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        check({tag, " port"},  32'(p), 32'(e.port));
        check({tag, " rdata"}, p ? bus.rsp1_rdata : bus.rsp0_rdata, e.rdata);
        check({tag, " err"},   32'(p ? bus.rsp1_err : bus.rsp0_err), 32'(e.err));
    endtask

    task automatic run_vec(input vec_t r, input string tag);
        bit ok;
        int lat, en_cnt;
        bit bus_ok;
        @(negedge clk);
        drive_req(r.port, 1'b1, r);
        bus.mem_ld_avail = 1'b0;
        bus.mem_sd_avail = 1'b0;
        wait_ready(r.port, tag, ok);
        if (!ok) begin
            drive_req(r.port, 1'b0, r);
            return;
        end
        sb.push_back('{r.port, r.exp_rdata, r.exp_err});
        @(negedge clk);
        drive_req(r.port, 1'b0, r);
        lat = 1; en_cnt = 0; bus_ok = 1'b1; ok = 1'b0;
        while (lat <= 40) begin
            if ((r.port ? bus.rsp1_valid : bus.rsp0_valid) === 1'b1) begin
                ok = 1'b1;
                break;
            end
            if (bus.mem_en === 1'b1) begin
                en_cnt++;
                if (bus.mem_addr !== r.addr || bus.mem_we !== r.we || bus.mem_size !== r.size)
                    bus_ok = 1'b0;
                bus.mem_ld_avail = (en_cnt > r.stall);
                bus.mem_sd_avail = (en_cnt > r.stall);
            end
            @(negedge clk);
            lat++;
        end
        bus.mem_ld_avail = 1'b1;
        bus.mem_sd_avail = 1'b1;
        if (!ok) begin
            check({tag, " response timeout"}, 32'd0, 32'd1);
            void'(sb.pop_front());
            return;
        end
        pop_check(r.port, tag);
        check({tag, " other rsp_valid"}, 32'(r.port ? bus.rsp0_valid : bus.rsp1_valid), 32'd0);
        check({tag, " latency"}, 32'(lat), r.exp_err ? 32'd1 : 32'(2 + r.stall));
        check({tag, " mem_en cycles"}, 32'(en_cnt), r.exp_err ? 32'd0 : 32'(1 + r.stall));
        if (!r.exp_err) check({tag, " mem bus stable"}, 32'(bus_ok), 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    vec_t vecs[16];
    vec_t ld0, ld1;

    initial begin
        bit ok;
        bit order[8];
        int c0, c1, ng;
        bit stable;

        reset = 1'b1;
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        bus.req0_addr = '0; bus.req1_addr = '0; bus.req0_wdata = '0; bus.req1_wdata = '0;
        bus.req0_we = 1'b0; bus.req1_we = 1'b0; bus.req0_size = SZ_W; bus.req1_size = SZ_W;
        bus.req0_unsigned = 1'b0; bus.req1_unsigned = 1'b0;
        bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;
        bus.mem_ld_avail = 1'b1; bus.mem_sd_avail = 1'b1;

        vecs[0]  = mk(1'b0, 1'b1, SZ_W, 1'b0, 32'h10, 32'hDEADBEEF, 0, 32'h0,        1'b0);
        vecs[1]  = mk(1'b0, 1'b0, SZ_W, 1'b0, 32'h10, 32'h0,        0, 32'hDEADBEEF, 1'b0);
        vecs[2]  = mk(1'b1, 1'b0, SZ_H, 1'b0, 32'h13, 32'h0,        0, 32'h0,        1'b1);
        vecs[3]  = mk(1'b0, 1'b0, SZ_W, 1'b0, 32'h10, 32'h0,        3, 32'hDEADBEEF, 1'b0);
        vecs[4]  = mk(1'b1, 1'b0, SZ_B, 1'b0, 32'h11, 32'h0,        0, 32'hFFFFFFBE, 1'b0);
        vecs[5]  = mk(1'b0, 1'b0, SZ_B, 1'b1, 32'h13, 32'h0,        0, 32'h000000DE, 1'b0);
        vecs[6]  = mk(1'b1, 1'b0, SZ_H, 1'b0, 32'h12, 32'h0,        0, 32'hFFFFDEAD, 1'b0);
        vecs[7]  = mk(1'b0, 1'b0, SZ_H, 1'b1, 32'h10, 32'h0,        0, 32'h0000BEEF, 1'b0);
        vecs[8]  = mk(1'b1, 1'b1, SZ_B, 1'b0, 32'h20, 32'hFFFFFF5A, 1, 32'h0,        1'b0);
        vecs[9]  = mk(1'b0, 1'b1, SZ_H, 1'b0, 32'h22, 32'hABCD1234, 0, 32'h0,        1'b0);
        vecs[10] = mk(1'b1, 1'b0, SZ_W, 1'b0, 32'h20, 32'h0,        0, 32'h1234005A, 1'b0);
        vecs[11] = mk(1'b0, 1'b0, SZ_X, 1'b0, 32'h20, 32'h0,        0, 32'h0,        1'b1);
        vecs[12] = mk(1'b1, 1'b0, SZ_W, 1'b0, 32'h22, 32'h0,        0, 32'h0,        1'b1);
        vecs[13] = mk(1'b0, 1'b1, SZ_W, 1'b0, 32'h21, 32'hFFFFFFFF, 0, 32'h0,        1'b1);
        vecs[14] = mk(1'b1, 1'b0, SZ_W, 1'b0, 32'h20, 32'h0,        0, 32'h1234005A, 1'b0);
        vecs[15] = mk(1'b0, 1'b0, SZ_H, 1'b1, 32'h22, 32'h0,        2, 32'h00001234, 1'b0);
        ld0 = mk(1'b0, 1'b0, SZ_W, 1'b0, 32'h10, 32'h0, 0, 32'hDEADBEEF, 1'b0);
        ld1 = mk(1'b1, 1'b0, SZ_W, 1'b0, 32'h20, 32'h0, 0, 32'h1234005A, 1'b0);

        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Reset state, then first contention goes to port 0.
        @(negedge clk);
        check("reset outputs",
              32'({bus.req0_ready, bus.req1_ready, bus.rsp0_valid, bus.rsp1_valid,
                   bus.mem_en, bus.mem_we}), 32'd0);
        check("reset mem_addr", bus.mem_addr, 32'h0);
        drive_req(1'b0, 1'b1, ld0);
        drive_req(1'b1, 1'b1, ld1);
        #1;
        check("reset first grant", 32'({bus.req1_ready, bus.req0_ready}), 32'b01);
        drive_req(1'b0, 1'b0, ld0);
        drive_req(1'b1, 1'b0, ld1);

        foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Contention: both ports keep valid high until four loads each are granted.
        do_reset();
        c0 = 0; c1 = 0; ng = 0;
        for (int cyc = 0; cyc < 300 && (ng < 8 || sb.size() > 0); cyc++) begin
            @(negedge clk);
            if (bus.rsp0_valid === 1'b1) pop_check(1'b0, "contend rsp0");
            if (bus.rsp1_valid === 1'b1) pop_check(1'b1, "contend rsp1");
            drive_req(1'b0, c0 < 4, ld0);
            drive_req(1'b1, c1 < 4, ld1);
            #1;
            if (bus.req0_valid && bus.req0_ready === 1'b1) begin
                if (ng < 8) order[ng] = 1'b0;
                ng++; c0++;
                sb.push_back('{1'b0, 32'hDEADBEEF, 1'b0});
            end
            if (bus.req1_valid && bus.req1_ready === 1'b1) begin
                if (ng < 8) order[ng] = 1'b1;
                ng++; c1++;
                sb.push_back('{1'b1, 32'h1234005A, 1'b0});
            end
        end
        drive_req(1'b0, 1'b0, ld0);
        drive_req(1'b1, 1'b0, ld1);
        check("contend grant count", 32'(ng), 32'd8);
        for (int i = 0; i < 8; i++) begin
`ifdef DMEM_ARB_RR_EN
            check($sformatf("contend grant%0d", i), 32'(order[i]), 32'(i % 2));
`else
            check($sformatf("contend grant%0d", i), 32'(order[i]), (i >= 4) ? 32'd1 : 32'd0);
`endif
        end

        // Response back-pressure on port 0 while port 1 waits.
        @(negedge clk);
        bus.rsp0_ready = 1'b0;
        drive_req(1'b0, 1'b1, ld0);
        wait_ready(1'b0, "bp", ok);
        sb.push_back('{1'b0, 32'hDEADBEEF, 1'b0});
        @(negedge clk);
        drive_req(1'b0, 1'b0, ld0);
        drive_req(1'b1, 1'b1, ld1);
        wait_rsp(1'b0, "bp", ok);
        stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (bus.rsp0_valid !== 1'b1 || bus.rsp0_rdata !== 32'hDEADBEEF ||
                bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) stable = 1'b0;
            @(negedge clk);
        end
        check("bp held stable", 32'(stable), 32'd1);
        pop_check(1'b0, "bp rsp0");
        bus.rsp0_ready = 1'b1;
        @(negedge clk);
        #1;
        check("bp port1 accepted next", 32'(bus.req1_ready), 32'd1);
        sb.push_back('{1'b1, 32'h1234005A, 1'b0});
        @(negedge clk);
        drive_req(1'b1, 1'b0, ld1);
        wait_rsp(1'b1, "bp port1", ok);
        if (ok) pop_check(1'b1, "bp rsp1");

        // Reset while in ISSUE: response discarded.
        @(negedge clk);
        bus.mem_ld_avail = 1'b0;
        drive_req(1'b0, 1'b1, ld0);
        wait_ready(1'b0, "rst issue", ok);
        @(negedge clk);
        drive_req(1'b0, 1'b0, ld0);
        check("rst issue in ISSUE", 32'(bus.mem_en), 32'd1);
        do_reset();
        check("rst issue idle",
              32'({bus.mem_en, bus.mem_we, bus.rsp0_valid, bus.rsp1_valid}), 32'd0);
        bus.mem_ld_avail = 1'b1;
        @(negedge clk);
        check("rst issue no rsp", 32'({bus.rsp0_valid, bus.rsp1_valid}), 32'd0);

        // Complete a port 0 access so last grant is port 0, then reset while in RESP.
        run_vec(ld0, "pre rst");
        @(negedge clk);
        bus.rsp0_ready = 1'b0;
        drive_req(1'b0, 1'b1, ld0);
        wait_ready(1'b0, "rst resp", ok);
        @(negedge clk);
        drive_req(1'b0, 1'b0, ld0);
        wait_rsp(1'b0, "rst resp", ok);
        do_reset();
        bus.rsp0_ready = 1'b1;
        check("rst resp idle",
              32'({bus.mem_en, bus.rsp0_valid, bus.rsp1_valid}), 32'd0);
        drive_req(1'b0, 1'b1, ld0);
        drive_req(1'b1, 1'b1, ld1);
        #1;
        check("rst resp first grant", 32'({bus.req1_ready, bus.req0_ready}), 32'b01);
        drive_req(1'b0, 1'b0, ld0);
        drive_req(1'b1, 1'b0, ld1);
        @(negedge clk);
        check("scoreboard drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
